// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register file with scoreboard.
package regfile_pkg;

  localparam int W_DEF     = 16;
  localparam int DEPTH_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending bit per storage register plus combinational busy lookup for both read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_idx,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_wr_q,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [AW-1:0] i_src0,
  input  logic [AW-1:0] i_src1,
  output logic          o_busy0,
  output logic          o_busy1
);

  logic [DEPTH-2:0] r_pend;

  // Issue is applied after write-back so a same-cycle issue leaves the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i_clr_en && i_clr_idx == AW'(i))
          r_pend[i] <= 1'b0;
        else if (i_set_en && i_set_addr == AW'(i))
          r_pend[i] <= 1'b1;
        else if (i_wr_q && i_wr_addr == AW'(i))
          r_pend[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    o_busy0 = 1'b0;
    o_busy1 = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i_src0 == AW'(i))
        o_busy0 = r_pend[i] && !(i_wr_q && i_wr_addr == i_src0);
      if (i_src1 == AW'(i))
        o_busy1 = r_pend[i] && !(i_wr_q && i_wr_addr == i_src1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write bypass, PC alias at the top address,
// an issue scoreboard and a sequential one-register-per-cycle clear.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] src0,
  input  logic [AW-1:0] src1,
  output logic [W-1:0]  rd0,
  output logic [W-1:0]  rd1,
  output logic          busy0,
  output logic          busy1,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [W-1:0]  pc_in,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_addr,
  input  logic          clr_req,
  output logic          clr_busy
);

  localparam logic [AW-1:0] PC_ADDR = AW'(DEPTH - 1);

  state_t         r_state;
  logic [AW-1:0]  r_cnt;
  logic [W-1:0]   r_regs [DEPTH-1];
  logic           w_idle;
  logic           w_wr_q;
  logic           w_clr_en;

  assign w_idle   = (r_state == IDLE);
  assign w_wr_q   = wr_en && w_idle && (wr_addr != PC_ADDR);
  assign w_clr_en = (r_state == CLEAR);
  assign clr_busy = w_clr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (clr_req)
            r_state <= CLEAR;
        end
        CLEAR: begin
          if (r_cnt == AW'(DEPTH - 2)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH - 1; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (w_clr_en && r_cnt == AW'(i))
          r_regs[i] <= '0;
        else if (w_wr_q && wr_addr == AW'(i))
          r_regs[i] <= wr_data;
      end
    end
  end

  // Top address aliases pc_in; otherwise a same-cycle write wins over storage.
  always_comb begin
    rd0 = pc_in;
    rd1 = pc_in;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (src0 == AW'(i))
        rd0 = (w_wr_q && wr_addr == src0) ? wr_data : r_regs[i];
      if (src1 == AW'(i))
        rd1 = (w_wr_q && wr_addr == src1) ? wr_data : r_regs[i];
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_clr_en   (w_clr_en),
    .i_clr_idx  (r_cnt),
    .i_set_en   (issue_en && w_idle),
    .i_set_addr (issue_addr),
    .i_wr_q     (w_wr_q),
    .i_wr_addr  (wr_addr),
    .i_src0     (src0),
    .i_src1     (src1),
    .o_busy0    (busy0),
    .o_busy1    (busy1)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb with an expectation queue and a separate monitor.
module tb_regfile_sb;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PC    = DEPTH - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] src0, src1;
  logic [W-1:0]  rd0, rd1;
  logic          busy0, busy1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  pc_in;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          clr_req;
  logic          clr_busy;

  regfile_sb #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .src0       (src0),
    .src1       (src1),
    .rd0        (rd0),
    .rd1        (rd1),
    .busy0      (busy0),
    .busy1      (busy1),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pc_in      (pc_in),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic         b0;
    logic         b1;
    logic         cb;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: plain array of values, pending flags, and how many registers remain to clear.
  logic [W-1:0] m_mem  [DEPTH];
  bit           m_pend [DEPTH];
  int           m_clr_rem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_clr_rem = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   wr_live;
    wr_live = (m_clr_rem == 0) && wr_en && (int'(wr_addr) != PC);
    e.cb  = (m_clr_rem > 0);
    e.rd0 = (int'(src0) == PC) ? pc_in : (wr_live && wr_addr == src0) ? wr_data : m_mem[src0];
    e.rd1 = (int'(src1) == PC) ? pc_in : (wr_live && wr_addr == src1) ? wr_data : m_mem[src1];
    e.b0  = (int'(src0) != PC) && m_pend[src0] && !(wr_live && wr_addr == src0);
    e.b1  = (int'(src1) != PC) && m_pend[src1] && !(wr_live && wr_addr == src1);
    return e;
  endfunction

  function automatic void model_clock();
    int idx;
    if (reset) return;
    if (m_clr_rem > 0) begin
      idx = (DEPTH - 1) - m_clr_rem;
      m_mem[idx]  = '0;
      m_pend[idx] = 1'b0;
      m_clr_rem--;
    end else begin
      if (wr_en && int'(wr_addr) != PC) begin
        m_mem[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (issue_en && int'(issue_addr) != PC)
        m_pend[issue_addr] = 1'b1;
      if (clr_req)
        m_clr_rem = DEPTH - 1;
    end
  endfunction

  // First half of a cycle: inputs already applied at the falling edge; queue the expectation.
  task automatic pre();
    #1;
    if (reset) model_zero();
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic post();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; issue_en = 1'b0; clr_req = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd0", 32'(rd0), 32'(e.rd0));
        chk("rd1", 32'(rd1), 32'(e.rd1));
        chk("busy0", 32'(busy0), 32'(e.b0));
        chk("busy1", 32'(busy1), 32'(e.b1));
        chk("clr_busy", 32'(clr_busy), 32'(e.cb));
      end
    end
  end

  initial begin : stim
    reset = 1'b1; src0 = '0; src1 = 4'd15; wr_addr = '0; wr_data = '0;
    pc_in = 16'h5A5A; issue_addr = '0;
    idle_inputs();
    model_zero();
    @(negedge clk);

    // Reset state
    pre();
    chk("reset_rd0", 32'(rd0), 32'h0);
    chk("reset_rd1_pc", 32'(rd1), 32'h5A5A);
    chk("reset_clr_busy", 32'(clr_busy), 32'h0);
    post();
    step();
    reset = 1'b0;

    // Write then read
    src1 = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; step();
    wr_en = 1'b0; src0 = 4'd3;
    pre(); chk("wr_then_rd", 32'(rd0), 32'h1234); post();

    // Same-cycle bypass
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; src1 = 4'd5;
    pre(); chk("bypass_rd1", 32'(rd1), 32'hBEEF); post();

    // PC alias ignores writes
    pc_in = 16'h00A0; wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'hFFFF; step();
    wr_en = 1'b0; src0 = 4'd15;
    pre(); chk("pc_rd0", 32'(rd0), 32'h00A0); chk("pc_busy0", 32'(busy0), 32'h0); post();

    // Scoreboard set / clear / issue-wins
    issue_en = 1'b1; issue_addr = 4'd7; step();
    issue_en = 1'b0; src0 = 4'd7;
    pre(); chk("issue_busy", 32'(busy0), 32'h1); post();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0777;
    pre(); chk("wr_clears_busy", 32'(busy0), 32'h0); post();
    issue_en = 1'b1; issue_addr = 4'd7; step();
    idle_inputs();
    pre(); chk("issue_wins", 32'(busy0), 32'h1); post();
    issue_en = 1'b1; issue_addr = 4'd15; step();
    idle_inputs(); src0 = 4'd15;
    pre(); chk("pc_never_busy", 32'(busy0), 32'h0); post();

    // Full clear with writes attempted throughout
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'(16'h1000 + i); step();
    end
    wr_en = 1'b0; clr_req = 1'b1; step();
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_en = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH - 2)); wr_data = 16'hDEAD;
      pre(); chk("clr_busy_hi", 32'(clr_busy), 32'h1); post();
    end
    wr_en = 1'b0;
    pre(); chk("clr_busy_lo", 32'(clr_busy), 32'h0); post();
    for (int i = 0; i < DEPTH - 1; i++) begin
      src0 = AW'(i); src1 = AW'(i); step();
    end

    // Clear requested together with a write: write lands, then is zeroed
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hCAFE; clr_req = 1'b1; step();
    idle_inputs(); src0 = 4'd2;
    for (int i = 0; i < DEPTH; i++) step();

    // Reset during clear cycle 6
    for (int i = 0; i < DEPTH - 1; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'(16'h2000 + i); issue_en = 1'b1; issue_addr = AW'(i); step();
    end
    idle_inputs(); clr_req = 1'b1; step();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1; src0 = 4'd10; src1 = 4'd12;
    pre(); chk("rst_mid_clr_busy", 32'(clr_busy), 32'h0); chk("rst_mid_rd0", 32'(rd0), 32'h0); post();
    reset = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      src0 = AW'(i); src1 = AW'(DEPTH - 2 - i); step();
    end
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h0909; step();
    wr_en = 1'b0; src0 = 4'd9;
    pre(); chk("idle_after_rst", 32'(rd0), 32'h0909); post();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      src0       = AW'($urandom_range(0, DEPTH - 1));
      src1       = AW'($urandom_range(0, DEPTH - 1));
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'($urandom_range(0, DEPTH - 1));
      wr_data    = W'($urandom);
      issue_en   = ($urandom_range(0, 9) < 3);
      issue_addr = AW'($urandom_range(0, DEPTH - 1));
      clr_req    = ($urandom_range(0, 99) < 3);
      pc_in      = W'($urandom);
      step();
    end
    idle_inputs();

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
